// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types and default sizing for the elevator motion controller
package elevator_pkg;

    localparam int N_FLOORS_DEF      = 8;
    localparam int TRAVEL_CYCLES_DEF = 4;
    localparam int DOOR_CYCLES_DEF   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2,
        SOS  = 2'd3
    } state_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    function automatic dir_e flip_dir(input dir_e d);
        return (d == DIR_UP) ? DIR_DOWN : DIR_UP;
    endfunction

endpackage

// File: rtl/floor_request_reg.sv
// rtl/floor_request_reg.sv - pending floor-request bitmap with position flags
module floor_request_reg
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF,
    parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [FLOOR_W-1:0]  set_floor,
    input  logic                clr_en,
    input  logic [FLOOR_W-1:0]  clr_floor,
    input  logic                flush,
    input  logic [FLOOR_W-1:0]  ref_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                req_above,
    output logic                req_below,
    output logic                req_here
);

    logic [N_FLOORS-1:0] pending_q;
    logic [N_FLOORS-1:0] pending_d;

    // Clear beats a same-edge set so a request for the floor being served is absorbed.
    always_comb begin
        pending_d = pending_q;
        if (set_en) begin
            pending_d[set_floor] = 1'b1;
        end
        if (clr_en) begin
            pending_d[clr_floor] = 1'b0;
        end
        if (flush) begin
            pending_d = '0;
        end
    end

    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending_q[i] && (i > int'(ref_floor))) begin
                req_above = 1'b1;
            end
            if (pending_q[i] && (i < int'(ref_floor))) begin
                req_below = 1'b1;
            end
        end
        req_here = pending_q[ref_floor];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/elevator_motion_ctrl.sv
// rtl/elevator_motion_ctrl.sv - collective-scheduling car motion and door controller with SOS override
module elevator_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS      = N_FLOORS_DEF,
    parameter int FLOOR_W       = $clog2(N_FLOORS),
    parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
    parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sos_mode,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic                moving_up,
    output logic                moving_down,
    output logic                door_open,
    output logic                sos_active,
    output logic [N_FLOORS-1:0] pending
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0]      T_LAST    = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      D_LAST    = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W:0]   FLOOR_LIM = (FLOOR_W + 1)'(N_FLOORS);

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
    logic [TW-1:0]      travel_cnt_q, travel_cnt_d;
    logic [DW-1:0]      door_cnt_q, door_cnt_d;
    logic               moving_up_q, moving_up_d;
    logic               moving_down_q, moving_down_d;
    logic               door_open_q, door_open_d;
    logic               sos_active_q, sos_active_d;

    logic               arrive;
    logic [FLOOR_W-1:0] next_floor;
    logic               req_ok;
    logic               here_hit;
    logic               set_en, clr_en, flush;
    logic               req_above, req_below, req_here;
    logic               go_ahead, go_behind;
    state_e             pick_state;
    dir_e               pick_dir;

    // Floor the car will occupy after this edge; the request flags are judged from there.
    always_comb begin
        arrive     = (state_q == MOVE) && (travel_cnt_q == T_LAST);
        next_floor = cur_floor_q;
        if (arrive) begin
            next_floor = (dir_q == DIR_UP) ? cur_floor_q + FLOOR_W'(1)
                                           : cur_floor_q - FLOOR_W'(1);
        end
    end

    floor_request_reg #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_req (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_en),
        .set_floor (req_floor),
        .clr_en    (clr_en),
        .clr_floor (next_floor),
        .flush     (flush),
        .ref_floor (next_floor),
        .pending   (pending),
        .req_above (req_above),
        .req_below (req_below),
        .req_here  (req_here)
    );

    always_comb begin
        req_ok    = req_valid && ({1'b0, req_floor} < FLOOR_LIM) && !sos_mode;
        here_hit  = req_here || (req_ok && (req_floor == next_floor));
        go_ahead  = (dir_q == DIR_UP) ? req_above : req_below;
        go_behind = (dir_q == DIR_UP) ? req_below : req_above;
        set_en    = req_ok && (state_q != SOS)
                    && !((state_q == DOOR) && (req_floor == cur_floor_q));
    end

    // Keep going the current way while work remains ahead, otherwise turn around or rest.
    always_comb begin
        pick_state = IDLE;
        pick_dir   = dir_q;
        if (go_ahead) begin
            pick_state = MOVE;
        end else if (go_behind) begin
            pick_state = MOVE;
            pick_dir   = flip_dir(dir_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cur_floor_d  = cur_floor_q;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
        clr_en       = 1'b0;
        flush        = 1'b0;

        if (sos_mode) begin
            state_d      = SOS;
            travel_cnt_d = '0;
            door_cnt_d   = '0;
            flush        = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_here) begin
                        state_d    = DOOR;
                        door_cnt_d = '0;
                        clr_en     = 1'b1;
                    end else begin
                        state_d      = pick_state;
                        dir_d        = pick_dir;
                        travel_cnt_d = '0;
                    end
                end
                MOVE: begin
                    if (!arrive) begin
                        travel_cnt_d = travel_cnt_q + TW'(1);
                    end else begin
                        travel_cnt_d = '0;
                        cur_floor_d  = next_floor;
                        if (here_hit) begin
                            state_d    = DOOR;
                            door_cnt_d = '0;
                            clr_en     = 1'b1;
                        end else begin
                            state_d = pick_state;
                            dir_d   = pick_dir;
                        end
                    end
                end
                DOOR: begin
                    if (req_ok && (req_floor == cur_floor_q)) begin
                        door_cnt_d = '0;
                    end else if (door_cnt_q == D_LAST) begin
                        door_cnt_d   = '0;
                        travel_cnt_d = '0;
                        state_d      = pick_state;
                        dir_d        = pick_dir;
                    end else begin
                        door_cnt_d = door_cnt_q + DW'(1);
                    end
                end
                SOS: begin
                    state_d    = IDLE;
                    door_cnt_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        moving_up_d   = (state_d == MOVE) && (dir_d == DIR_UP);
        moving_down_d = (state_d == MOVE) && (dir_d == DIR_DOWN);
        // An open door stays open through an emergency that began while it was open.
        door_open_d   = (state_d == DOOR) || ((state_d == SOS) && door_open_q);
        sos_active_d  = (state_d == SOS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dir_q         <= DIR_UP;
            cur_floor_q   <= '0;
            travel_cnt_q  <= '0;
            door_cnt_q    <= '0;
            moving_up_q   <= 1'b0;
            moving_down_q <= 1'b0;
            door_open_q   <= 1'b0;
            sos_active_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            cur_floor_q   <= cur_floor_d;
            travel_cnt_q  <= travel_cnt_d;
            door_cnt_q    <= door_cnt_d;
            moving_up_q   <= moving_up_d;
            moving_down_q <= moving_down_d;
            door_open_q   <= door_open_d;
            sos_active_q  <= sos_active_d;
        end
    end

    assign cur_floor   = cur_floor_q;
    assign moving_up   = moving_up_q;
    assign moving_down = moving_down_q;
    assign door_open   = door_open_q;
    assign sos_active  = sos_active_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// tb/tb_elevator_motion_ctrl.sv - self-checking bench for elevator_motion_ctrl
module tb_elevator_motion_ctrl;

    localparam int NF = 8;
    localparam int TC = 4;
    localparam int DC = 6;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DOOR = 2;
    localparam int M_HALT = 3;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       sos_mode  = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_floor = 3'd0;
    logic [2:0] cur_floor;
    logic       moving_up, moving_down, door_open, sos_active;
    logic [7:0] pending;

    logic       req_valid6 = 1'b0;
    logic [2:0] req_floor6 = 3'd0;
    logic [2:0] cur_floor6;
    logic       mu6, md6, do6, sa6;
    logic [5:0] pending6;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    int        m_mode = M_IDLE;
    int        m_floor = 0;
    int        m_left = 0;
    bit        m_up = 1'b1;
    bit        m_door_hold = 1'b0;
    bit [NF-1:0] m_pend = '0;

    always #5 clk = ~clk;

    elevator_motion_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sos_mode    (sos_mode),
        .req_valid   (req_valid),
        .req_floor   (req_floor),
        .cur_floor   (cur_floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .sos_active  (sos_active),
        .pending     (pending)
    );

    elevator_motion_ctrl #(.N_FLOORS(6)) u_dut6 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sos_mode    (1'b0),
        .req_valid   (req_valid6),
        .req_floor   (req_floor6),
        .cur_floor   (cur_floor6),
        .moving_up   (mu6),
        .moving_down (md6),
        .door_open   (do6),
        .sos_active  (sa6),
        .pending     (pending6)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Collective policy: keep heading toward outstanding calls, turn only when none lie ahead.
    task automatic m_decide(input bit [NF-1:0] snap);
        bit above = 1'b0;
        bit below = 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (snap[i] && i > m_floor) above = 1'b1;
            if (snap[i] && i < m_floor) below = 1'b1;
        end
        m_left = TC;
        if (m_up ? above : below) begin
            m_mode = M_RUN;
        end else if (m_up ? below : above) begin
            m_up   = !m_up;
            m_mode = M_RUN;
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    task automatic model_step(input bit sos, input bit rv, input int rf);
        bit [NF-1:0] snap = m_pend;
        bit take = rv && (rf < NF) && !sos && (m_mode != M_HALT);
        if (sos) begin
            m_door_hold = (m_mode == M_DOOR) || ((m_mode == M_HALT) && m_door_hold);
            m_mode = M_HALT;
            m_pend = '0;
            return;
        end
        case (m_mode)
            M_HALT: begin
                m_mode = M_IDLE;
                m_door_hold = 1'b0;
            end
            M_IDLE: begin
                if (take) m_pend[rf] = 1'b1;
                if (snap[m_floor]) begin
                    m_mode = M_DOOR;
                    m_left = DC;
                    m_pend[m_floor] = 1'b0;
                end else begin
                    m_decide(snap);
                end
            end
            M_RUN: begin
                if (take) m_pend[rf] = 1'b1;
                m_left--;
                if (m_left == 0) begin
                    m_floor += m_up ? 1 : -1;
                    if (snap[m_floor] || (take && rf == m_floor)) begin
                        m_mode = M_DOOR;
                        m_left = DC;
                        m_pend[m_floor] = 1'b0;
                    end else begin
                        m_decide(snap);
                    end
                end
            end
            default: begin
                if (take && rf == m_floor) begin
                    m_left = DC;
                end else begin
                    if (take) m_pend[rf] = 1'b1;
                    m_left--;
                    if (m_left == 0) m_decide(snap);
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_floor = 0;
            m_left = 0;
            m_up = 1'b1;
            m_door_hold = 1'b0;
            m_pend = '0;
        end else begin
            model_step(sos_mode, req_valid, int'(req_floor));
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("cyc_cur_floor",   int'(cur_floor),   m_floor);
            chk("cyc_moving_up",   int'(moving_up),   int'(m_mode == M_RUN && m_up));
            chk("cyc_moving_down", int'(moving_down), int'(m_mode == M_RUN && !m_up));
            chk("cyc_door_open",   int'(door_open),   int'(m_mode == M_DOOR || (m_mode == M_HALT && m_door_hold)));
            chk("cyc_sos_active",  int'(sos_active),  int'(m_mode == M_HALT));
            chk("cyc_pending",     int'(pending),     int'(m_pend));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input int f);
        req_valid = 1'b1;
        req_floor = 3'(f);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_door(input bit want, output int cycles);
        cycles = 0;
        while ((door_open != want) && cycles < 200) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        int cnt;
        bit saw_down;

        repeat (3) tick();
        chk("rst_cur_floor", int'(cur_floor), 0);
        chk("rst_moving_up", int'(moving_up), 0);
        chk("rst_moving_dn", int'(moving_down), 0);
        chk("rst_door_open", int'(door_open), 0);
        chk("rst_sos_active", int'(sos_active), 0);
        chk("rst_pending", int'(pending), 0);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        tick();

        // Single call to floor 3 from rest at floor 0.
        pulse(3);
        chk("t1_pend_set", int'(pending), 8'h08);
        chk("t1_up_early", int'(moving_up), 0);
        tick();
        chk("t1_up_start", int'(moving_up), 1);
        chk("t1_model_up", int'(m_mode == M_RUN && m_up), 1);
        repeat (3) tick();
        chk("t1_floor0_hold", int'(cur_floor), 0);
        tick();
        chk("t1_floor1", int'(cur_floor), 1);
        repeat (4) tick();
        chk("t1_floor2", int'(cur_floor), 2);
        repeat (4) tick();
        chk("t1_floor3", int'(cur_floor), 3);
        chk("t1_door_at3", int'(door_open), 1);
        chk("t1_pend_clr", int'(pending), 0);
        wait_door(1'b0, cnt);
        chk("t1_door_len", cnt, 6);
        chk("t1_idle_up", int'(moving_up), 0);
        chk("t1_model_floor", m_floor, 3);

        // Calls above and below while heading up: upper one first.
        pulse(5);
        pulse(1);
        chk("t2_pend_both", int'(pending), 8'h22);
        saw_down = 1'b0;
        cnt = 0;
        while (!door_open && cnt < 200) begin
            saw_down |= moving_down;
            cnt++;
            tick();
        end
        chk("t2_door5_open", int'(door_open), 1);
        chk("t2_first_stop", int'(cur_floor), 5);
        chk("t2_no_early_down", int'(saw_down), 0);
        wait_door(1'b0, cnt);
        chk("t2_door5_len", cnt, 6);
        chk("t2_down_after", int'(moving_down), 1);
        wait_door(1'b1, cnt);
        chk("t2_second_stop", int'(cur_floor), 1);
        chk("t2_model_stop", m_floor, 1);
        wait_door(1'b0, cnt);
        chk("t2_pend_empty", int'(pending), 0);

        // Repeat call for the floor whose door is open.
        pulse(3);
        wait_door(1'b1, cnt);
        chk("t3_at3", int'(cur_floor), 3);
        repeat (2) tick();
        pulse(3);
        chk("t3_pend3_stays", int'(pending[3]), 0);
        wait_door(1'b0, cnt);
        chk("t3_door_after_last", cnt, 6);

        // Emergency mid-travel between floors 2 and 3.
        pulse(2);
        wait_door(1'b1, cnt);
        wait_door(1'b0, cnt);
        chk("t4_at2", int'(cur_floor), 2);
        pulse(6);
        tick();
        chk("t4_moving", int'(moving_up), 1);
        tick();
        sos_mode = 1'b1;
        tick();
        chk("t4_halt_up", int'(moving_up), 0);
        chk("t4_sos_on", int'(sos_active), 1);
        chk("t4_flushed", int'(pending), 0);
        chk("t4_floor_held", int'(cur_floor), 2);
        chk("t4_door_shut", int'(door_open), 0);
        pulse(5);
        chk("t4_req_ignored", int'(pending), 0);
        tick();
        sos_mode = 1'b0;
        tick();
        chk("t4_sos_off", int'(sos_active), 0);
        repeat (3) tick();
        chk("t4_stays_idle", int'(moving_up), 0);
        chk("t4_stays_empty", int'(pending), 0);

        // Emergency while the door is open.
        pulse(2);
        wait_door(1'b1, cnt);
        chk("t5_door_open", int'(door_open), 1);
        tick();
        sos_mode = 1'b1;
        tick();
        chk("t5_sos_door", int'(door_open), 1);
        chk("t5_sos_on", int'(sos_active), 1);
        repeat (3) tick();
        chk("t5_sos_door_hold", int'(door_open), 1);
        sos_mode = 1'b0;
        tick();
        chk("t5_exit_door", int'(door_open), 0);
        chk("t5_exit_sos", int'(sos_active), 0);

        // Out-of-range floors on a six-floor car.
        chk("t6_u6_floor", int'(cur_floor6), 0);
        chk("t6_u6_idle", int'({mu6, md6, do6, sa6}), 0);
        req_valid6 = 1'b1;
        req_floor6 = 3'd6;
        tick();
        chk("t6_drop6", int'(pending6), 0);
        req_floor6 = 3'd7;
        tick();
        chk("t6_drop7", int'(pending6), 0);
        req_floor6 = 3'd5;
        tick();
        req_valid6 = 1'b0;
        chk("t6_take5", int'(pending6), 6'h20);

        // Asynchronous reset in the middle of a run.
        pulse(7);
        cnt = 0;
        while (cur_floor != 3'd4 && cnt < 200) begin
            cnt++;
            tick();
        end
        chk("t6_pre_floor", int'(cur_floor), 4);
        chk("t6_pre_moving", int'(moving_up), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_floor", int'(cur_floor), 0);
        chk("t6_rst_up", int'(moving_up), 0);
        chk("t6_rst_pend", int'(pending), 0);
        chk("t6_rst_flags", int'({moving_down, door_open, sos_active}), 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_post_idle", int'(moving_up), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got timeout, want finish");
        $fatal(1);
    end

endmodule
